// File: rtl/zorro_cycle_watchdog.sv
// Zorro III bus-cycle watchdog: forces DTACK on hung slave cycles and converts hung or BERR'd DMA cycles into a bus error.
// Optional saturating timeout statistics are built when WATCHDOG_STATS_EN is defined.
`timescale 1ns/1ps
module zorro_cycle_watchdog #(
  parameter int SLAVE_TIMEOUT  = 255,
  parameter int MASTER_TIMEOUT = 1023,
  parameter int CW             = 10
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       bfcs,
  input  logic       slave_start,
  input  logic       slave_ack,
  input  logic       BMASTER,
  input  logic       DTACK_n,
  input  logic       BERR_n,
  input  logic       wd_clear,
  output logic       slave_abort,
  output logic       master_berr,
  output logic       timeout_flag,
  output logic [7:0] slave_to_cnt,
  output logic [7:0] master_to_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SLAVE_WAIT  = 3'd1,
    ST_MASTER_WAIT = 3'd2,
    ST_ABORT       = 3'd3,
    ST_DRAIN       = 3'd4
  } state_t;

  localparam logic [CW-1:0] SLV_TC   = CW'(SLAVE_TIMEOUT - 1);
  localparam logic [CW-1:0] MST_TC   = CW'(MASTER_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_dtack_meta;
  logic          r_dtack_sync;
  logic          r_berr_meta;
  logic          r_berr_sync;
  logic          r_slave_abort;
  logic          r_master_berr;
  logic          r_timeout_flag;
  logic          w_dtack_s;
  logic          w_berr_s;
  logic          w_slave_to;
  logic          w_master_err;

  // Two-flop synchronizers for the asynchronous bus terminations, preset to negated.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_dtack_meta <= 1'b1;
      r_dtack_sync <= 1'b1;
      r_berr_meta  <= 1'b1;
      r_berr_sync  <= 1'b1;
    end else begin
      r_dtack_meta <= DTACK_n;
      r_dtack_sync <= r_dtack_meta;
      r_berr_meta  <= BERR_n;
      r_berr_sync  <= r_berr_meta;
    end
  end

  assign w_dtack_s = ~r_dtack_sync;
  assign w_berr_s  = ~r_berr_sync;

  // Next-state, cycle counter and timeout-event decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_slave_to   = 1'b0;
    w_master_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = CNT_ZERO;
        if (bfcs && BMASTER) begin
          w_state_nxt = ST_MASTER_WAIT;
        end else if (bfcs && slave_start) begin
          w_state_nxt = ST_SLAVE_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SLAVE_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (!bfcs) begin
          w_state_nxt = ST_IDLE;
        end else if (slave_ack) begin
          w_state_nxt = ST_DRAIN;
        end else if (r_cnt == SLV_TC) begin
          w_state_nxt = ST_ABORT;
          w_slave_to  = 1'b1;
        end else begin
          w_state_nxt = ST_SLAVE_WAIT;
        end
      end
      ST_MASTER_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        // BERR outranks DTACK; DTACK outranks the terminal count.
        if (!bfcs) begin
          w_state_nxt = ST_IDLE;
        end else if (!BMASTER) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_berr_s) begin
          w_state_nxt  = ST_DRAIN;
          w_master_err = 1'b1;
        end else if (w_dtack_s) begin
          w_state_nxt = ST_DRAIN;
        end else if (r_cnt == MST_TC) begin
          w_state_nxt  = ST_DRAIN;
          w_master_err = 1'b1;
        end else begin
          w_state_nxt = ST_MASTER_WAIT;
        end
      end
      ST_ABORT: begin
        w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bfcs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered status outputs.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= CNT_ZERO;
      r_slave_abort  <= 1'b0;
      r_master_berr  <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_slave_abort <= (w_state_nxt == ST_ABORT);
      if (w_state_nxt == ST_IDLE) begin
        r_master_berr <= 1'b0;
      end else if (w_master_err) begin
        r_master_berr <= 1'b1;
      end else begin
        r_master_berr <= r_master_berr;
      end
      if (w_slave_to || w_master_err) begin
        r_timeout_flag <= 1'b1;
      end else if (wd_clear) begin
        r_timeout_flag <= 1'b0;
      end else begin
        r_timeout_flag <= r_timeout_flag;
      end
    end
  end

  assign slave_abort  = r_slave_abort;
  assign master_berr  = r_master_berr;
  assign timeout_flag = r_timeout_flag;

`ifdef WATCHDOG_STATS_EN
  logic [7:0] r_slave_to_cnt;
  logic [7:0] r_master_to_cnt;

  function automatic logic [7:0] stat_next(input logic [7:0] cnt, input logic inc, input logic clr);
    if (inc && clr) begin
      return 8'd1;
    end else if (inc) begin
      return (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
    end else if (clr) begin
      return 8'd0;
    end else begin
      return cnt;
    end
  endfunction

  // Saturating timeout statistics; an increment outranks a same-cycle clear.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_slave_to_cnt  <= 8'd0;
      r_master_to_cnt <= 8'd0;
    end else begin
      r_slave_to_cnt  <= stat_next(r_slave_to_cnt, w_slave_to, wd_clear);
      r_master_to_cnt <= stat_next(r_master_to_cnt, w_master_err, wd_clear);
    end
  end

  assign slave_to_cnt  = r_slave_to_cnt;
  assign master_to_cnt = r_master_to_cnt;
`else
  assign slave_to_cnt  = 8'h00;
  assign master_to_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_zorro_cycle_watchdog.sv
// Scoreboard bench for zorro_cycle_watchdog: expectations are queued as stimulus is driven and popped as outputs appear.
`timescale 1ns/1ps
module tb_zorro_cycle_watchdog;
  localparam int ST = 255;
  localparam int MT = 1023;
`ifdef WATCHDOG_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  localparam int NSAT = (STATS != 0) ? 260 : 3;

  logic       CLK;
  logic       RESET_n;
  logic       bfcs;
  logic       slave_start;
  logic       slave_ack;
  logic       BMASTER;
  logic       DTACK_n;
  logic       BERR_n;
  logic       wd_clear;
  logic       slave_abort;
  logic       master_berr;
  logic       timeout_flag;
  logic [7:0] slave_to_cnt;
  logic [7:0] master_to_cnt;

  zorro_cycle_watchdog #(.SLAVE_TIMEOUT(ST), .MASTER_TIMEOUT(MT), .CW(10)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .bfcs(bfcs), .slave_start(slave_start),
    .slave_ack(slave_ack), .BMASTER(BMASTER), .DTACK_n(DTACK_n), .BERR_n(BERR_n),
    .wd_clear(wd_clear), .slave_abort(slave_abort), .master_berr(master_berr),
    .timeout_flag(timeout_flag), .slave_to_cnt(slave_to_cnt), .master_to_cnt(master_to_cnt)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_abort(output int n);
    n = 0;
    while (slave_abort !== 1'b1 && n < ST + 20) begin
      tick();
      n++;
    end
    if (slave_abort !== 1'b1) n = -1;
  endtask

  task automatic wait_berr(output int n);
    n = 0;
    while (master_berr !== 1'b1 && n < MT + 20) begin
      tick();
      n++;
    end
    if (master_berr !== 1'b1) n = -1;
  endtask

  task automatic slave_timeout(output int lat);
    bfcs = 1'b1;
    slave_start = 1'b1;
    tick();
    wait_abort(lat);
    bfcs = 1'b0;
    slave_start = 1'b0;
    tick();
    tick();
  endtask

  task automatic clear_pulse();
    wd_clear = 1'b1;
    tick();
    wd_clear = 1'b0;
  endtask

  initial begin
    #(40 * 150000);
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time budget exhausted");
  end

  initial begin
    int n;
    int cnt;
    bfcs = 1'b0; slave_start = 1'b0; slave_ack = 1'b0; BMASTER = 1'b0;
    DTACK_n = 1'b1; BERR_n = 1'b1; wd_clear = 1'b0; RESET_n = 1'b0;

    expect_val("reset_outputs", 0);
    repeat (3) tick();
    sb_check({slave_abort, master_berr, timeout_flag, slave_to_cnt, master_to_cnt});
    RESET_n = 1'b1;
    tick();

    // Slave cycle acknowledged on the 5th cycle.
    expect_val("ack_aborts", 0);
    expect_val("ack_flag", 0);
    bfcs = 1'b1; slave_start = 1'b1;
    tick();
    cnt = 0;
    repeat (4) begin tick(); cnt += int'(slave_abort); end
    slave_ack = 1'b1;
    tick();
    cnt += int'(slave_abort);
    slave_ack = 1'b0;
    repeat (3) begin tick(); cnt += int'(slave_abort); end
    bfcs = 1'b0; slave_start = 1'b0;
    tick();
    sb_check(cnt);
    sb_check(timeout_flag);

    // Slave cycle never acknowledged.
    expect_val("sto_latency", ST);
    expect_val("sto_pulse_end", 0);
    expect_val("sto_flag", 1);
    expect_val("sto_scnt", STATS);
    expect_val("sto_clr_flag", 0);
    expect_val("sto_clr_scnt", 0);
    bfcs = 1'b1; slave_start = 1'b1;
    tick();
    wait_abort(n);
    sb_check(n);
    tick();
    sb_check(slave_abort);
    sb_check(timeout_flag);
    sb_check(slave_to_cnt);
    bfcs = 1'b0; slave_start = 1'b0;
    tick();
    clear_pulse();
    sb_check(timeout_flag);
    sb_check(slave_to_cnt);

    // DMA cycle terminated by DTACK_n.
    expect_val("dma_dtack_berr", 0);
    expect_val("dma_dtack_flag", 0);
    BMASTER = 1'b1; bfcs = 1'b1;
    tick();
    repeat (2) tick();
    DTACK_n = 1'b0;
    cnt = 0;
    repeat (MT + 10) begin tick(); cnt += int'(master_berr); end
    sb_check(cnt);
    sb_check(timeout_flag);
    DTACK_n = 1'b1; bfcs = 1'b0; BMASTER = 1'b0;
    tick();
    tick();

    // DMA cycle with BERR_n and DTACK_n together: bus error wins.
    expect_val("dma_berr_latency", 3);
    expect_val("dma_berr_hold", 1);
    expect_val("dma_berr_flag", 1);
    expect_val("dma_berr_mcnt", STATS);
    expect_val("dma_berr_release", 0);
    BMASTER = 1'b1; bfcs = 1'b1;
    tick();
    tick();
    BERR_n = 1'b0; DTACK_n = 1'b0;
    n = 0;
    while (master_berr !== 1'b1 && n < 10) begin tick(); n++; end
    sb_check(n);
    BERR_n = 1'b1; DTACK_n = 1'b1;
    repeat (5) tick();
    sb_check(master_berr);
    sb_check(timeout_flag);
    sb_check(master_to_cnt);
    bfcs = 1'b0;
    tick();
    sb_check(master_berr);
    BMASTER = 1'b0;
    clear_pulse();

    // DMA cycle timeout, then asynchronous reset while the error is held.
    expect_val("mto_latency", MT);
    expect_val("mto_hold", 1);
    expect_val("mto_rst_berr", 0);
    expect_val("mto_rst_flag", 0);
    BMASTER = 1'b1; bfcs = 1'b1;
    tick();
    wait_berr(n);
    sb_check(n);
    repeat (3) tick();
    sb_check(master_berr);
    #5 RESET_n = 1'b0;
    #1;
    sb_check(master_berr);
    sb_check(timeout_flag);
    bfcs = 1'b0; BMASTER = 1'b0;
    tick();
    RESET_n = 1'b1;
    tick();

    // DTACK arriving exactly at the master terminal count.
    expect_val("mtc_dtack_berr", 0);
    expect_val("mtc_dtack_flag", 0);
    BMASTER = 1'b1; bfcs = 1'b1;
    tick();
    repeat (MT - 3) tick();
    DTACK_n = 1'b0;
    cnt = 0;
    repeat (10) begin tick(); cnt += int'(master_berr); end
    sb_check(cnt);
    sb_check(timeout_flag);
    DTACK_n = 1'b1; bfcs = 1'b0; BMASTER = 1'b0;
    tick();
    tick();

    // slave_ack exactly at the slave terminal count.
    expect_val("stc_ack_aborts", 0);
    expect_val("stc_ack_flag", 0);
    bfcs = 1'b1; slave_start = 1'b1;
    tick();
    repeat (ST - 1) tick();
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0;
    cnt = int'(slave_abort);
    repeat (3) begin tick(); cnt += int'(slave_abort); end
    sb_check(cnt);
    sb_check(timeout_flag);
    bfcs = 1'b0; slave_start = 1'b0;
    tick();
    tick();

    // Repeated slave timeouts drive the statistic into saturation.
    expect_val("sat_latency", ST);
    expect_val("sat_scnt", (STATS != 0) ? 255 : 0);
    expect_val("sat_mcnt", 0);
    for (int i = 0; i < NSAT; i++) slave_timeout(n);
    sb_check(n);
    sb_check(slave_to_cnt);
    sb_check(master_to_cnt);

    // wd_clear on the same edge as a new timeout: set wins, count restarts at 1.
    expect_val("clr_race_abort", 1);
    expect_val("clr_race_flag", 1);
    expect_val("clr_race_scnt", STATS);
    expect_val("final_clr_flag", 0);
    bfcs = 1'b1; slave_start = 1'b1;
    tick();
    repeat (ST - 1) tick();
    wd_clear = 1'b1;
    tick();
    wd_clear = 1'b0;
    sb_check(slave_abort);
    sb_check(timeout_flag);
    sb_check(slave_to_cnt);
    bfcs = 1'b0; slave_start = 1'b0;
    tick();
    tick();
    clear_pulse();
    sb_check(timeout_flag);

    check("sb_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
